// File: rtl/omem_readout_ctrl_if.sv
// rtl/omem_readout_ctrl_if.sv - O-Memory drain control, read port and output stream bundle
`ifndef MAX_CORE_BITS
`define MAX_CORE_BITS 4
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 16
`endif

interface omem_readout_ctrl_if #(
  parameter int CORE_BITS = `MAX_CORE_BITS,
  parameter int ADDR_W    = `WB_WIDTH,
  parameter int DATA_W    = `WB_WIDTH
);
  // drain request
  logic                 iStart;
  logic [CORE_BITS:0]   iCoreCount;
  logic [ADDR_W-1:0]    iWordsPerCore;
  // O-Memory read port
  logic [CORE_BITS-1:0] oOMEMBankSelect;
  logic [ADDR_W-1:0]    oOMEMReadAddress;
  logic [DATA_W-1:0]    iOMEMData;
  // output word stream
  logic [DATA_W-1:0]    oData;
  logic                 oValid;
  logic                 iReady;
  logic                 oLast;
  // status
  logic                 oBusy;
  logic                 oDone;

  // the readout controller
  modport master (
    input  iStart, iCoreCount, iWordsPerCore, iOMEMData, iReady,
    output oOMEMBankSelect, oOMEMReadAddress, oData, oValid, oLast, oBusy, oDone
  );

  // the surroundings: requester, O-Memory and frame collector
  modport slave (
    output iStart, iCoreCount, iWordsPerCore, iOMEMData, iReady,
    input  oOMEMBankSelect, oOMEMReadAddress, oData, oValid, oLast, oBusy, oDone
  );
endinterface

// File: rtl/omem_readout_ctrl.sv
// rtl/omem_readout_ctrl.sv - drains per-core O-Memory bank by bank onto a valid/ready stream
`ifndef MAX_CORE_BITS
`define MAX_CORE_BITS 4
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 16
`endif

module omem_readout_ctrl #(
  parameter int CORE_BITS    = `MAX_CORE_BITS,
  parameter int ADDR_W       = `WB_WIDTH,
  parameter int DATA_W       = `WB_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic Clock,
  input  logic Reset,
  omem_readout_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // latency counter is 3 bits wide, enough for READ_LATENCY up to 7
  localparam logic [2:0]         LAT_LOAD = 3'(READ_LATENCY);
  localparam logic [CORE_BITS:0] BANK_ONE = {{CORE_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [CORE_BITS:0] core_count;
  logic [ADDR_W-1:0]  words;
  // one extra bank bit so a count of 2^CORE_BITS compares without wrapping
  logic [CORE_BITS:0] bank;
  logic [ADDR_W-1:0]  addr;
  logic [2:0]         lat_cnt;
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               last;
  logic               busy;
  logic               done;
  logic               final_word;
  logic               bank_end;

  // counts are known nonzero whenever these are consulted (WAIT/OUT only)
  assign bank_end   = (addr == words - ADDR_ONE);
  assign final_word = (bank == core_count - BANK_ONE) && bank_end;

  // drain sequencer; every output comes straight from a register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      core_count <= '0;
      words      <= '0;
      bank       <= '0;
      addr       <= '0;
      lat_cnt    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            core_count <= bus.iCoreCount;
            words      <= bus.iWordsPerCore;
            bank       <= '0;
            addr       <= '0;
            lat_cnt    <= LAT_LOAD;
            busy       <= 1'b1;
            if ((bus.iCoreCount == '0) || (bus.iWordsPerCore == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          // address has been stable for READ_LATENCY edges when the count reaches 1
          if (lat_cnt == 3'd1) begin
            data  <= bus.iOMEMData;
            valid <= 1'b1;
            last  <= final_word;
            state <= OUT;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        OUT: begin
          if (bus.iReady) begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (bank_end) begin
              addr    <= '0;
              bank    <= bank + BANK_ONE;
              lat_cnt <= LAT_LOAD;
              state   <= WAIT;
            end else begin
              addr    <= addr + ADDR_ONE;
              lat_cnt <= LAT_LOAD;
              state   <= WAIT;
            end
          end
        end

        DONE: begin
          // oDone was raised on entry; both it and oBusy drop on this edge
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
          last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oOMEMBankSelect  = bank[CORE_BITS-1:0];
  assign bus.oOMEMReadAddress = addr;
  assign bus.oData            = data;
  assign bus.oValid           = valid;
  assign bus.oLast            = last;
  assign bus.oBusy            = busy;
  assign bus.oDone            = done;

endmodule
